// File: rtl/cdc_s2f_tx.sv
// Slow-domain launcher for the slow-to-fast CDC bus: buffers words in a small FIFO
// and presents each one for HOLD_CYC+1 cycles, qualified by a one-cycle data_en pulse.
module cdc_s2f_tx #(
    parameter int DW       = 4,
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 3
) (
    input  logic                     clk_a,
    input  logic                     arst,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            data_out,
    output logic                     data_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [LW-1:0]   r_level;
    logic [DW-1:0]   r_dout;
    logic            r_den;
    logic            w_push, w_pop, w_nonempty;

    assign w_nonempty = (r_level != '0);
    // Ready depends only on the registered level, never on a same-cycle pop.
    assign in_ready   = (r_level != LW'(DEPTH));
    assign w_push     = in_valid & in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = CW'(HOLD_CYC - 1);
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_den   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_den   <= w_pop;
            if (w_pop) r_dout <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge clk_a) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

    always_ff @(posedge clk_a or posedge arst) begin
        if (arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign data_out   = r_dout;
    assign data_en    = r_den;
    assign busy       = (r_state != IDLE) | w_nonempty;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_cdc_s2f_tx.sv
// Bench for cdc_s2f_tx: two instances (HOLD_CYC=3 and 1) share stimulus and are each
// compared every cycle against a queue-plus-launch-window reference model.
module tb_cdc_s2f_tx;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_a = 1'b0;
    logic          arst  = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          rdy [2];
    logic [DW-1:0] dout [2];
    logic          den [2];
    logic          bsy [2];
    logic [LW-1:0] lvl [2];

    always #5 clk_a = ~clk_a;

    cdc_s2f_tx #(.DW(DW), .DEPTH(DEPTH), .HOLD_CYC(3)) u_h3 (
        .clk_a(clk_a), .arst(arst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .data_out(dout[0]), .data_en(den[0]), .busy(bsy[0]),
        .fifo_level(lvl[0]));

    cdc_s2f_tx #(.DW(DW), .DEPTH(DEPTH), .HOLD_CYC(1)) u_h1 (
        .clk_a(clk_a), .arst(arst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .data_out(dout[1]), .data_en(den[1]), .busy(bsy[1]),
        .fifo_level(lvl[1]));

    int errors = 0;
    int checks = 0;

    // Reference model: a word queue, the last launched word, and the earliest edge
    // at which the next launch may happen.
    logic [DW-1:0] mq [2][$];
    logic [DW-1:0] eout [2];
    int            nok [2];
    int            npush [2];
    int            nden [2];
    int            cyc = 0;
    bit            pushed0;

    function automatic int hc_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            eout[k]  = '0;
            nok[k]   = 0;
            npush[k] = 0;
            nden[k]  = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.den%0d", tag, k), int'(den[k]), 0);
            chk($sformatf("%s.dout%0d", tag, k), int'(dout[k]), 0);
            chk($sformatf("%s.lvl%0d", tag, k), int'(lvl[k]), 0);
            chk($sformatf("%s.rdy%0d", tag, k), int'(rdy[k]), 1);
            chk($sformatf("%s.busy%0d", tag, k), int'(bsy[k]), 0);
        end
    endtask

    // One clock edge: decide model pop/push from pre-edge state, then compare.
    task automatic tick();
        bit psh [2];
        bit pp  [2];
        bit een;
        int e;
        e = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            psh[k] = in_valid && (mq[k].size() < DEPTH);
            pp[k]  = (mq[k].size() > 0) && (e >= nok[k]);
        end
        @(posedge clk_a);
        cyc = e;
        #1;
        pushed0 = psh[0];
        for (int k = 0; k < 2; k++) begin
            een = 1'b0;
            if (pp[k]) begin
                eout[k] = mq[k].pop_front();
                nok[k]  = e + hc_of(k) + 1;
                een     = 1'b1;
            end
            if (psh[k]) begin
                mq[k].push_back(in_data);
                npush[k]++;
            end
            if (den[k]) nden[k]++;
            chk($sformatf("den%0d", k), int'(den[k]), int'(een));
            chk($sformatf("dout%0d", k), int'(dout[k]), int'(eout[k]));
            chk($sformatf("lvl%0d", k), int'(lvl[k]), mq[k].size());
            chk($sformatf("rdy%0d", k), int'(rdy[k]), int'(mq[k].size() < DEPTH));
            chk($sformatf("busy%0d", k), int'(bsy[k]),
                int'((mq[k].size() > 0) || (cyc < nok[k])));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int w;
        int guard;
        mreset();
        #12;
        chk_reset("rst");
        @(negedge clk_a);
        arst = 1'b0;

        // single word
        in_valid = 1'b1; in_data = 4'h5;
        tick();
        idle(8);

        // three back-to-back words
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            tick();
        end
        idle(14);

        // continuous stream 0xA..0xF, advancing on acceptance by the HOLD_CYC=3 copy
        w = 'hA; guard = 0;
        while (w <= 'hF && guard < 100) begin
            in_valid = 1'b1; in_data = DW'(w);
            tick();
            if (pushed0) w++;
            guard++;
        end
        chk("stream_bound", int'(w > 'hF), 1);
        idle(30);
        for (int k = 0; k < 2; k++)
            chk($sformatf("stream_cnt%0d", k), nden[k], npush[k]);

        // reset while holding with words queued
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            tick();
        end
        idle(1);
        chk("pre_rst_lvl0", int'(lvl[0]), 3);
        #2 arst = 1'b1;
        #1;
        mreset();
        chk_reset("midrst");
        @(negedge clk_a);
        arst = 1'b0;
        idle(10);

        // random traffic, 200 words into the HOLD_CYC=3 copy
        w = 0; guard = 0;
        while (w < 200 && guard < 5000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            tick();
            if (pushed0) w++;
            guard++;
        end
        chk("rand_bound", int'(w >= 200), 1);
        in_valid = 1'b0;
        guard = 0;
        while ((bsy[0] || bsy[1]) && guard < 200) begin
            tick();
            guard++;
        end
        chk("drain_bound", int'(guard < 200), 1);
        idle(3);
        for (int k = 0; k < 2; k++)
            chk($sformatf("rand_cnt%0d", k), nden[k], npush[k]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdc_s2f_tx.md
Name: cdc_s2f_tx

Overview:
Transmit-side launcher for the slow-to-fast multibit CDC bus (data word plus single-bit data_en qualifier) in the slow clk_a domain. Accepts a word stream over a valid/ready handshake and buffers it in a small FIFO. Launches one word at a time onto the CDC bus, then holds the word stable for a programmed number of clk_a cycles. This guarantees the fast-domain receiver's 2-flop data_en synchronizer captures each word before the bus changes.

Parameters:
DW, 4, data word width (matches receiver data_in width)
DEPTH, 4, input FIFO depth; power of 2, >= 2
HOLD_CYC, 3, clk_a cycles data_out stays stable after the data_en pulse; >= 1

Ports:
clk_a  input  1  slow clock; all logic on rising edge
arst  input  1  asynchronous, active-high reset
in_data  input  DW  word to send
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; push = in_valid & in_ready
data_out  output  DW  CDC bus data, drives receiver data_in; registered
data_en  output  1  CDC bus qualifier, one-cycle pulse per word; registered
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release), all outputs and state cleared:
  - data_out=0, data_en=0, FIFO empty, fifo_level=0, state=IDLE, hold counter=0.
  - in_ready=1 after reset.
  - Assertion mid-operation drops all queued words; data_en goes low immediately.
- FIFO:
  - in_ready = !full, registered from occupancy only. Not combinationally raised by a same-cycle pop.
  - Push while full is impossible by construction.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: level unchanged, data order preserved.
  - fifo_level updates at the same edge as push/pop.
- FSM, states IDLE, SEND, HOLD:
  - IDLE: if FIFO non-empty at edge, pop head; data_out<=head, data_en<=1; go SEND.
  - SEND lasts exactly 1 cycle with data_en=1. Next edge: data_en<=0, counter<=HOLD_CYC-1, go HOLD.
  - HOLD: data_en=0, data_out unchanged; counter decrements each edge.
  - Last HOLD cycle (counter==0): if FIFO non-empty, pop and launch as from IDLE (go SEND); else go IDLE.
- Latency: word pushed into empty FIFO at edge t appears on data_out with data_en=1 after edge t+1. The word is not launched in the same cycle it is pushed.
- Throughput: consecutive data_en pulses are exactly HOLD_CYC+1 cycles apart when the FIFO stays non-empty; never closer.
- Stability: data_out changes only at a launch edge, and only together with data_en rising. It holds for >= HOLD_CYC+1 cycles.
- busy = (state!=IDLE) | (fifo_level!=0).
- No word is ever dropped or duplicated except by reset.

Test Plan:
- Reset, then push 0x5 at edge 0 into empty FIFO -> data_out=0x5, data_en=1 during cycle 1 only; data_out stays 0x5 through cycle 4; busy falls after cycle 4.
- Push 0x1,0x2,0x3 on edges 0,1,2 (HOLD_CYC=3) -> data_en pulses in cycles 1, 5, 9 with data_out 0x1, 0x2, 0x3; data_out constant between pulses.
- Hold in_valid=1 with 0xA..0xF continuously (DEPTH=4) -> in_ready drops when fifo_level=4; all six words emerge in order, one pulse per 4 cycles; no push accepted while in_ready=0.
- Assert arst during HOLD with 3 words queued -> data_en=0, data_out=0, fifo_level=0, in_ready=1 immediately; no further pulses after release until a new push.
- HOLD_CYC=1, stream 4 words -> pulses every 2 cycles; pop and push in the same cycle keep fifo_level constant.
- Scoreboard run: random in_valid (50%) for 200 words, paired with the receiver model -> receiver output sequence equals input sequence; data_out never changes while data_en=0 within the hold window.
